clken_synth: RTL and testbench
==============================

CLKEN_SYNTH -- requirements
Module: clken_synth

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent clock-enable channels (1..16).
REQ-002 Parameter ACC_W, default 32: phase-accumulator width in bits (8..48).
REQ-003 Parameter INC_RESET, default 32'hA8F5C28F: per-channel increment after reset (33 MHz from 50 MHz refclk).
REQ-004 Parameter LOCK_CYCLES, default 1024: number of stable cycles required before locked asserts.
REQ-005 refclk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 cfg_we  in  1  configuration write strobe, one write per asserted cycle.
REQ-008 cfg_ch  in  clog2(NUM_CH) (min 1)  channel index for the write.
REQ-009 cfg_inc  in  ACC_W  new phase increment.
REQ-010 cfg_en  in  1  channel enable value written with the increment.
REQ-011 clken  out  NUM_CH  per-channel single-cycle enable pulses, registered.
REQ-012 locked  out  1  configuration stable for LOCK_CYCLES cycles, registered.

Function
REQ-013 Each channel SHALL hold acc[ACC_W], inc_active, inc_pending, pend flag and en.
REQ-014 When en=1, each cycle {carry, acc} SHALL take acc + inc_active, modulo 2^ACC_W; clken[ch] SHALL equal carry one cycle later (latency 1).
REQ-015 inc_active=0 SHALL never pulse; inc_active=2^ACC_W-1 SHALL pulse on all but one cycle per 2^ACC_W.
REQ-016 A write with cfg_ch < NUM_CH SHALL load cfg_inc into inc_pending, set pend and load cfg_en into en immediately.
REQ-017 A pending increment SHALL commit to inc_active on the cycle its channel produces carry, so that pulse spacing never glitches mid-period.
REQ-018 A pending increment SHALL commit immediately on the next cycle if en=0 or inc_active=0.
REQ-019 A write to a channel with pend already set SHALL overwrite inc_pending; only the latest value commits.
REQ-020 A write and a carry on the same channel in the same cycle: the pre-write inc_pending (if pend) SHALL commit, and the new value SHALL remain pending.
REQ-021 Setting en=0 SHALL clear acc to 0 and force clken[ch] low from the next cycle; re-enabling SHALL restart from acc=0.
REQ-022 A write with cfg_ch >= NUM_CH SHALL be ignored entirely, including by the lock logic.
REQ-023 The lock counter SHALL reset to 0 in any cycle with a valid write or with any pend set, and otherwise increment, saturating at LOCK_CYCLES.
REQ-024 locked SHALL be 1 exactly when the lock counter equals LOCK_CYCLES.

Reset
REQ-025 On rst=1 at a refclk edge: acc=0, inc_active=INC_RESET, pend=0, en=1 for all channels; clken=0; locked=0; lock counter=0.
REQ-026 rst SHALL override any simultaneous cfg_we; a pending update in flight SHALL be discarded.

Structure
REQ-027 Package clken_synth_pkg SHALL hold the default parameter values, INC_RESET and named increment constants (INC_33M, INC_25M = 2^ACC_W/2).
REQ-028 One sub-module clken_synth_ch SHALL implement a single channel (acc, commit logic, clken register), instantiated NUM_CH times by generate.
REQ-029 Lock counter and write decode SHALL live in the top level.

Verification
REQ-030 Reset release, ch0 written with inc=32'h40000000 at cycle 0 -> ch0 commits immediately after its first carry; clken[0] pulses every 4 cycles thereafter.
REQ-031 Default config, no writes -> each clken averages 33 pulses per 50 cycles (±1 over 5000 cycles); locked rises exactly LOCK_CYCLES cycles after rst falls.
REQ-032 inc 32'h40000000 active, write 32'h80000000 mid-period -> old 4-cycle spacing completes, then 2-cycle spacing; locked drops on the write cycle and recovers LOCK_CYCLES cycles after commit.
REQ-033 Two writes to ch1 (inc=8, then inc=16) before its carry -> only 16 commits; same-cycle write+carry follows REQ-020.
REQ-034 Write cfg_en=0 to ch2 -> clken[2] low from the next cycle; re-enable -> first pulse timing restarts from acc=0; write with cfg_ch=NUM_CH leaves all state and locked unchanged.
REQ-035 Assert rst for 1 cycle while a pending update exists -> all outputs return to reset values on the next cycle, and pend is cleared.

Source files
------------

// File: rtl/clken_synth_pkg.sv
// Shared defaults and named phase increments for the fractional clock-enable synthesizer.
// Increments assume a 50 MHz reference clock and a 32-bit accumulator.
package clken_synth_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_ACC_W       = 32;
    localparam int DEF_LOCK_CYCLES = 1024;

    // 33 MHz and 25 MHz enables from a 50 MHz reference, 32-bit accumulator
    localparam logic [31:0] INC_33M   = 32'hA8F5C28F;
    localparam logic [31:0] INC_25M   = 32'h80000000;
    localparam logic [31:0] INC_RESET = INC_33M;

    // Width of a channel index; a single channel still gets a 1-bit port
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Half-rate increment (2^acc_w / 2) for an arbitrary accumulator width
    function automatic logic [47:0] inc_half(input int acc_w);
        return 48'(1) << (acc_w - 1);
    endfunction

endpackage

// File: rtl/clken_synth_ch.sv
// One clock-enable channel: phase accumulator, glitch-free increment update and
// registered enable pulse.
module clken_synth_ch
    import clken_synth_pkg::*;
#(
    parameter int               ACC_W     = DEF_ACC_W,
    parameter logic [ACC_W-1:0] INC_RESET = ACC_W'(clken_synth_pkg::INC_RESET)
)(
    input  logic             clk,
    input  logic             srst,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic             wr_en,
    output logic             clken,
    output logic             pend
);

    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [ACC_W-1:0] inc_active_reg, inc_active_next;
    logic [ACC_W-1:0] inc_pending_reg, inc_pending_next;
    logic             pend_reg, pend_next;
    logic             en_reg, en_next;
    logic             clken_reg, clken_next;

    logic [ACC_W:0]   sum;
    logic             run;
    logic             carry;
    logic             commit;

    always_comb begin
        sum              = {1'b0, acc_reg} + {1'b0, inc_active_reg};
        // A disabling write stops the channel on its own edge so no pulse escapes
        run              = en_reg && !(wr && !wr_en);
        carry            = run && sum[ACC_W];
        // Swap the increment only at a period boundary, unless the channel is idle
        commit           = pend_reg && (carry || !en_reg || (inc_active_reg == '0));

        acc_next         = run ? sum[ACC_W-1:0] : '0;
        clken_next       = carry;
        inc_active_next  = commit ? inc_pending_reg : inc_active_reg;
        inc_pending_next = inc_pending_reg;
        pend_next        = pend_reg && !commit;
        en_next          = en_reg;

        // The commit above uses the pre-write pending value; a new write stays pending
        if (wr) begin
            inc_pending_next = wr_inc;
            pend_next        = 1'b1;
            en_next          = wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg         <= '0;
            inc_active_reg  <= INC_RESET;
            inc_pending_reg <= '0;
            pend_reg        <= 1'b0;
            en_reg          <= 1'b1;
            clken_reg       <= 1'b0;
        end else begin
            acc_reg         <= acc_next;
            inc_active_reg  <= inc_active_next;
            inc_pending_reg <= inc_pending_next;
            pend_reg        <= pend_next;
            en_reg          <= en_next;
            clken_reg       <= clken_next;
        end
    end

    assign clken = clken_reg;
    assign pend  = pend_reg;

endmodule

// File: rtl/clken_synth.sv
// Multi-channel fractional clock-enable synthesizer: write decode, per-channel
// accumulators and a lock indicator for configuration stability.
module clken_synth
    import clken_synth_pkg::*;
#(
    parameter int               NUM_CH      = DEF_NUM_CH,
    parameter int               ACC_W       = DEF_ACC_W,
    parameter logic [ACC_W-1:0] INC_RESET   = ACC_W'(clken_synth_pkg::INC_RESET),
    parameter int               LOCK_CYCLES = DEF_LOCK_CYCLES,
    localparam int              CH_W        = ch_idx_w(NUM_CH)
)(
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] clken,
    output logic              locked
);

    localparam int              LOCK_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

    logic              ch_ok;
    logic              wr_valid;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] ch_pend;
    logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic              locked_reg;

    // Out-of-range indices only exist when NUM_CH is not a power of two
    generate
        if (NUM_CH == (2 ** CH_W)) begin : g_full_range
            assign ch_ok = 1'b1;
        end else begin : g_part_range
            assign ch_ok = (cfg_ch <= CH_W'(NUM_CH - 1));
        end
    endgenerate

    assign wr_valid = cfg_we && ch_ok;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_wr[gi] = wr_valid && (cfg_ch == CH_W'(gi));

            clken_synth_ch #(
                .ACC_W     (ACC_W),
                .INC_RESET (INC_RESET)
            ) u_ch (
                .clk    (refclk),
                .srst   (rst),
                .wr     (ch_wr[gi]),
                .wr_inc (cfg_inc),
                .wr_en  (cfg_en),
                .clken  (clken[gi]),
                .pend   (ch_pend[gi])
            );
        end
    endgenerate

    // Any configuration activity restarts the stability count
    always_comb begin
        lock_cnt_next = lock_cnt_reg;
        if (wr_valid || (|ch_pend)) begin
            lock_cnt_next = '0;
        end else if (lock_cnt_reg != LOCK_MAX) begin
            lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else begin
            lock_cnt_reg <= lock_cnt_next;
            locked_reg   <= (lock_cnt_next == LOCK_MAX);
        end
    end

    assign locked = locked_reg;

endmodule

// File: tb/tb_clken_synth.sv
// Directed bench for clken_synth: three channels so an out-of-range index exists,
// short lock window; expected pulse patterns are hand-derived per edge.
module tb_clken_synth;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 64;
    localparam int CH_W        = 2;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              cfg_en;
    logic [NUM_CH-1:0] clken;
    logic              locked;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 refclk = ~refclk;

    clken_synth #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .INC_RESET   (32'hA8F5C28F),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk  (refclk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_inc (cfg_inc),
        .cfg_en  (cfg_en),
        .clken   (clken),
        .locked  (locked)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int ch, input logic [ACC_W-1:0] inc, input logic en);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_inc = inc;
        cfg_en  = en;
    endtask

    // Leaves rst low so the next step() is edge 0 of the following scenario
    task automatic do_reset();
        rst     = 1'b1;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_inc = '0;
        cfg_en  = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = -1;
    endtask

    initial begin
        int          cnt [NUM_CH];
        int          lock_at;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;

        // Default configuration: pulse density and lock timing
        do_reset();
        chk("reset_clken", 64'(clken), 64'd0);
        chk("reset_locked", 64'(locked), 64'd0);
        for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
        lock_at = 0;
        for (int k = 0; k < 5000; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) cnt[c] += int'(clken[c]);
            if (locked && lock_at == 0) lock_at = k + 1;
        end
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("density_ch%0d", c), 64'(cnt[c]), 64'd3299);
        chk("lock_rise_cycles", 64'(lock_at), 64'(LOCK_CYCLES));
        $display("scenario default: pulses=%0d/%0d/%0d lock_at=%0d", cnt[0], cnt[1], cnt[2], lock_at);

        // ch0 written with quarter-rate increment on the first cycle out of reset
        do_reset();
        v0 = '0;
        for (int k = 0; k <= 12; k++) begin
            cfg_we = 1'b0;
            if (k == 0) wr(0, 32'h40000000, 1'b1);
            step();
            v0[k] = clken[0];
            if (k == 0) chk("first_write_locked", 64'(locked), 64'd0);
        end
        cfg_we = 1'b0;
        chk("ch0_quarter_rate", 64'(v0[12:0]), 64'(13'b1000100010010));
        $display("scenario first write: ch0 pattern=%b", v0[12:0]);

        // Mid-period change to half rate, lock drop and recovery
        while (cyc < 69) step();
        chk("locked_before_change", 64'(locked), 64'd1);
        wr(0, 32'h80000000, 1'b1);
        step();
        cfg_we = 1'b0;
        v0 = '0;
        v0[0] = clken[0];
        chk("lock_drop_on_write", 64'(locked), 64'd0);
        for (int k = 1; k <= 10; k++) begin
            step();
            v0[k] = clken[0];
        end
        chk("mid_period_spacing", 64'(v0[10:0]), 64'(11'b10101010100));
        while (cyc < 135) step();
        chk("lock_not_yet", 64'(locked), 64'd0);
        step();
        chk("lock_recovered", 64'(locked), 64'd1);
        $display("scenario rate change: ch0 pattern=%b locked=%0d", v0[10:0], locked);

        // Out-of-range channel index must be invisible
        wr(3, 32'h0, 1'b0);
        step();
        cfg_we = 1'b0;
        v0 = '0;
        v0[0] = clken[0];
        chk("bad_ch_locked", 64'(locked), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            v0[k] = clken[0];
        end
        chk("bad_ch_pulses", 64'(v0[3:0]), 64'(4'b1010));
        chk("bad_ch_locked_after", 64'(locked), 64'd1);
        $display("scenario bad index: ch0 pattern=%b locked=%0d", v0[3:0], locked);

        // ch1: overwrite while pending, then write coinciding with a carry
        do_reset();
        v1 = '0;
        for (int k = 0; k <= 18; k++) begin
            cfg_we = 1'b0;
            case (k)
                0:  wr(1, 32'h40000000, 1'b1);
                2:  wr(1, 32'hC0000000, 1'b1);
                3:  wr(1, 32'h80000000, 1'b1);
                9:  wr(1, 32'h40000000, 1'b1);
                10: wr(1, 32'h80000000, 1'b1);
                default: ;
            endcase
            step();
            v1[k] = clken[1];
        end
        cfg_we = 1'b0;
        chk("pending_overwrite", 64'(v1[9:0]), 64'(10'b0101010010));
        chk("write_with_carry", 64'(v1[18:10]), 64'(9'b101010001));
        $display("scenario pending: ch1 pattern=%b", v1[18:0]);

        // ch2 disable/re-enable; ch0 zero increment and immediate commit from idle
        do_reset();
        v0 = '0;
        v2 = '0;
        for (int k = 0; k <= 16; k++) begin
            cfg_we = 1'b0;
            case (k)
                0: wr(2, 32'h40000000, 1'b1);
                1: wr(0, 32'h00000000, 1'b1);
                3: wr(2, 32'h40000000, 1'b0);
                5: wr(0, 32'h80000000, 1'b1);
                8: wr(2, 32'h40000000, 1'b1);
                default: ;
            endcase
            step();
            v0[k] = clken[0];
            v2[k] = clken[2];
        end
        cfg_we = 1'b0;
        chk("disable_forces_low", 64'(v2[11:0]), 64'h002);
        chk("reenable_restart", 64'(v2[16:12]), 64'(5'b10001));
        chk("zero_inc_silent", 64'(v0[6:0]), 64'(7'b0001010));
        chk("idle_commit", 64'(v0[16:7]), 64'(10'b0101010101));
        $display("scenario enable: ch0 pattern=%b ch2 pattern=%b", v0[16:0], v2[16:0]);

        // Reset pulse with an update in flight and a competing write
        do_reset();
        for (int k = 0; k <= 3; k++) begin
            cfg_we = 1'b0;
            if (k == 0) wr(0, 32'h80000000, 1'b1);
            if (k == 3) wr(0, 32'h20000000, 1'b1);
            step();
        end
        chk("pre_reset_pulses", 64'(clken[2:1]), 64'(2'b11));
        rst = 1'b1;
        wr(0, 32'hC0000000, 1'b1);
        step();
        chk("midrun_reset_clken", 64'(clken), 64'd0);
        chk("midrun_reset_locked", 64'(locked), 64'd0);
        rst    = 1'b0;
        cfg_we = 1'b0;
        cyc    = -1;
        v0 = '0;
        v1 = '0;
        for (int k = 0; k <= 8; k++) begin
            step();
            v0[k] = clken[0];
            v1[k] = clken[1];
        end
        chk("pend_discarded_ch0", 64'(v0[8:0]), 64'(9'b011011010));
        chk("post_reset_ch1", 64'(v1[8:0]), 64'(9'b011011010));
        $display("scenario reset: ch0 pattern=%b ch1 pattern=%b", v0[8:0], v1[8:0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
